// File: rtl/als_level_meter.sv
`default_nettype none
// ============================================================================
// Module   : als_level_meter
// Brief    : Samples the Pmod ALS frame on a periodic tick, box-averages the
//            ADC code, quantises it to a 0..10 bar level with drop hysteresis
//            and tracks a decaying peak marker for the LED bar.
// Revision : 1.0 - initial release
// ============================================================================
module als_level_meter #(
    parameter int SAMPLE_PERIOD     = 500000,
    parameter int AVG_LOG2          = 3,
    parameter int HYST              = 2,
    parameter int PEAK_HOLD_SAMPLES = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [7:0]  light,
    output logic        light_valid,
    output logic [3:0]  level,
    output logic [3:0]  peak,
    output logic [9:0]  leds
);

    localparam int c_DEPTH  = 1 << AVG_LOG2;
    localparam int c_SUM_W  = 8 + AVG_LOG2;
    localparam int c_CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int c_HOLD_W = $clog2(PEAK_HOLD_SAMPLES + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST    = c_CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_RELOAD = c_HOLD_W'(PEAK_HOLD_SAMPLES);
    localparam logic [8:0]          c_HYST9       = 9'(HYST);

    // Frame bits outside the ADC code are don't-care.
    logic       w_unused_bits;
    assign w_unused_bits = ^{value[15:12], value[3:0]};

    logic [7:0] w_sample;
    assign w_sample = value[11:4];

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic               w_tick;

    // Free-running sample-period counter; tick marks its last count.
    always_comb begin
        w_tick     = (tick_cnt_q == c_CNT_LAST);
        tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Tick counter register.
    always_ff @(posedge clock) begin
        if (reset) tick_cnt_q <= '0;
        else       tick_cnt_q <= tick_cnt_d;
    end

    // ------------------------------------------------------------------
    // Stage 1: sample window and running sum
    // ------------------------------------------------------------------
    logic [7:0]         buf_q [c_DEPTH];
    logic [c_SUM_W-1:0] sum_q;
    logic               s1_q;

    // Running sum adds the new sample and removes the one ageing out, so the
    // sum always equals the total of the buffer contents and never overflows.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) buf_q[i] <= '0;
            sum_q <= '0;
            s1_q  <= 1'b0;
        end else begin
            s1_q <= w_tick;
            if (w_tick) begin
                sum_q    <= sum_q + c_SUM_W'(w_sample) - c_SUM_W'(buf_q[c_DEPTH-1]);
                buf_q[0] <= w_sample;
                for (int i = 1; i < c_DEPTH; i++) buf_q[i] <= buf_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: average
    // ------------------------------------------------------------------
    logic [7:0] light_q;
    logic       light_valid_q;

    // Truncating divide by the window depth; valid pulses for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            light_q       <= '0;
            light_valid_q <= 1'b0;
        end else begin
            light_valid_q <= s1_q;
            if (s1_q) light_q <= sum_q[c_SUM_W-1:AVG_LOG2];
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: bar level, peak marker and LED drive
    // ------------------------------------------------------------------
    logic [3:0]          level_q, level_d;
    logic [3:0]          peak_q,  peak_d;
    logic [c_HOLD_W-1:0] hold_q,  hold_d;
    logic [9:0]          leds_q,  leds_d;
    logic [3:0]          w_raw;
    logic [8:0]          w_level_x25;

    // Quantise: count how many of the 25-code thresholds the average reaches.
    always_comb begin
        w_raw = '0;
        for (int k = 1; k <= 10; k++) begin
            if ({1'b0, light_q} >= 9'(25 * k)) w_raw = w_raw + 4'd1;
        end
    end

    // Level rises immediately but only drops once the average is clearly
    // below the current level's threshold; peak follows the new level.
    always_comb begin
        w_level_x25 = {5'd0, level_q} * 9'd25;
        level_d     = level_q;
        peak_d      = peak_q;
        hold_d      = hold_q;
        leds_d      = '0;

        if (w_raw > level_q) begin
            level_d = w_raw;
        end else if ((w_raw < level_q) && (({1'b0, light_q} + c_HYST9) < w_level_x25)) begin
            level_d = w_raw;
        end

        if (level_d >= peak_q) begin
            peak_d = level_d;
            hold_d = c_HOLD_RELOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else begin
            peak_d = peak_q - 4'd1;
            hold_d = c_HOLD_RELOAD;
        end

        for (int i = 0; i < 10; i++) begin
            leds_d[i] = (4'(i) < level_d) || (4'(i + 1) == peak_d);
        end
    end

    // Display registers update only when a fresh average is presented.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= '0;
            peak_q  <= '0;
            hold_q  <= '0;
            leds_q  <= '0;
        end else if (light_valid_q) begin
            level_q <= level_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            leds_q  <= leds_d;
        end
    end

    assign light       = light_q;
    assign light_valid = light_valid_q;
    assign level       = level_q;
    assign peak        = peak_q;
    assign leds        = leds_q;

endmodule
`default_nettype wire
